// File: rtl/rx_frame_loader.sv
// rx_frame_loader: packs UART bytes into 24-bit RGB pixels
// and writes them sequentially into BRAM port A.
module rx_frame_loader #(
  parameter int NUM_PIXELS     = 262144,
  parameter int TIMEOUT_CYCLES = 10_020_800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_received,
  input  logic        rx_data_ready,
  output logic        en,
  output logic        we,
  output logic [17:0] addr,
  output logic [23:0] din,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [17:0]   LAST_PIX = 18'(NUM_PIXELS - 1);
  localparam logic [IW-1:0] IDLE_LIM = IW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    idx;
  logic [7:0]    r_q;
  logic [7:0]    g_q;
  logic [17:0]   pix_cnt;
  logic [IW-1:0] idle_cnt;

  logic          accept;
  logic          do_write;
  logic          wr_cycle;
  logic          last_pix;
  logic          tmo;

  assign accept = rx_data_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_nxt = state;
    do_write  = 1'b0;
    wr_cycle  = 1'b0;
    last_pix  = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (accept) begin
          if (idx == 2'd2) begin
            state_nxt = WRITE;
            do_write  = 1'b1;
          end
        end else if (idle_cnt == IDLE_LIM) begin
          state_nxt = IDLE;
          tmo       = 1'b1;
        end
      end
      WRITE: begin
        wr_cycle = 1'b1;
        last_pix = (pix_cnt == LAST_PIX);
        if (accept) begin
          state_nxt = RECV;
        end else if (last_pix) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RECV;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Byte assembly: byte index and held R/G bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 2'd0;
      r_q <= 8'd0;
      g_q <= 8'd0;
    end else if (accept) begin
      if (idx == 2'd0) begin
        r_q <= byte_received;
      end
      if (idx == 2'd1) begin
        g_q <= byte_received;
      end
      idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else if (tmo) begin
      idx <= 2'd0;
    end
  end

  // Pixel address counter; wraps at the end of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= 18'd0;
    end else if (tmo) begin
      pix_cnt <= 18'd0;
    end else if (wr_cycle) begin
      pix_cnt <= last_pix ? 18'd0 : pix_cnt + 18'd1;
    end
  end

  // Idle counter: only runs while a frame is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (accept || state_nxt == IDLE) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  // BRAM port and status outputs, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en          <= 1'b0;
      we          <= 1'b0;
      addr        <= 18'd0;
      din         <= 24'd0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      en          <= do_write;
      we          <= do_write;
      busy        <= (state_nxt != IDLE);
      frame_done  <= wr_cycle && last_pix;
      timeout_err <= tmo;
      if (do_write) begin
        addr <= pix_cnt;
        din  <= {r_q, g_q, byte_received};
      end
    end
  end

endmodule
